// File: rtl/object_compositor.sv
`default_nettype none
// ============================================================================
// Module   : object_compositor
// Brief    : 3-stage per-pixel compositor for NUM_OBJ double-buffered
//            rectangle/circle objects, with priority colour select and
//            per-frame collision flags.
// Revision : 1.0 - initial release
// ============================================================================
module object_compositor #(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8,
    parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   cfg_wr,
    input  logic [IDX_W-1:0]       cfg_obj,
    input  logic                   cfg_en,
    input  logic                   cfg_shape,
    input  logic [COORD_W-1:0]     cfg_x,
    input  logic [COORD_W-1:0]     cfg_y,
    input  logic [COORD_W-1:0]     cfg_w,
    input  logic [COORD_W-1:0]     cfg_h,
    input  logic [3*COLOR_W-1:0]   cfg_rgb,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     DrawX,
    input  logic [COORD_W-1:0]     DrawY,
    output logic                   out_valid,
    output logic [COLOR_W-1:0]     Red,
    output logic [COLOR_W-1:0]     Green,
    output logic [COLOR_W-1:0]     Blue,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [NUM_OBJ-1:0]     frame_collision
);

    localparam int c_RGB_W = 3 * COLOR_W;
    localparam int c_SQ_W  = 2 * COORD_W + 3;
    localparam int c_BG_W  = (COORD_W - 3 > 8) ? COORD_W - 3 : 8;

    typedef struct packed {
        logic               en;
        logic               shape;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [c_RGB_W-1:0] rgb;
    } obj_t;

    obj_t r_shadow [NUM_OBJ];
    obj_t r_active [NUM_OBJ];

    // Non-blocking copy means a same-cycle write lands in shadow only.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_OBJ; i++) r_active[i] <= r_shadow[i];
            end
            if (cfg_wr) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    if (cfg_obj == IDX_W'(i))
                        r_shadow[i] <= {cfg_en, cfg_shape, cfg_x, cfg_y, cfg_w, cfg_h, cfg_rgb};
                end
            end
        end
    end

    // ---------------- S1: offsets (two's complement) and field snapshot
    logic [COORD_W:0]   r_s1Dx    [NUM_OBJ];
    logic [COORD_W:0]   r_s1Dy    [NUM_OBJ];
    logic               r_s1En    [NUM_OBJ];
    logic               r_s1Shape [NUM_OBJ];
    logic [COORD_W-1:0] r_s1W     [NUM_OBJ];
    logic [COORD_W-1:0] r_s1H     [NUM_OBJ];
    logic [c_RGB_W-1:0] r_s1Rgb   [NUM_OBJ];
    logic [COLOR_W-1:0] r_s1Bg;
    logic               r_s1Valid;

    logic [c_BG_W-1:0]  w_bgFull;
    assign w_bgFull = c_BG_W'(8'h7F) - c_BG_W'(DrawX[COORD_W-1:3]);

    always_ff @(posedge Clk) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            r_s1Dx[i]    <= {1'b0, DrawX} - {1'b0, r_active[i].x};
            r_s1Dy[i]    <= {1'b0, DrawY} - {1'b0, r_active[i].y};
            r_s1En[i]    <= r_active[i].en;
            r_s1Shape[i] <= r_active[i].shape;
            r_s1W[i]     <= r_active[i].w;
            r_s1H[i]     <= r_active[i].h;
            r_s1Rgb[i]   <= r_active[i].rgb;
        end
        r_s1Bg <= COLOR_W'(w_bgFull);
    end

    // ---------------- S2: magnitudes, squares, coverage
    logic [COORD_W:0]   w_absDx [NUM_OBJ];
    logic [COORD_W:0]   w_absDy [NUM_OBJ];
    logic [c_SQ_W-1:0]  w_dist  [NUM_OBJ];
    logic [c_SQ_W-1:0]  w_rad   [NUM_OBJ];
    logic [NUM_OBJ-1:0] w_cover;

    always_comb begin
        w_cover = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            w_absDx[i] = r_s1Dx[i][COORD_W] ? (~r_s1Dx[i] + 1'b1) : r_s1Dx[i];
            w_absDy[i] = r_s1Dy[i][COORD_W] ? (~r_s1Dy[i] + 1'b1) : r_s1Dy[i];
            w_dist[i]  = c_SQ_W'(w_absDx[i]) * c_SQ_W'(w_absDx[i])
                       + c_SQ_W'(w_absDy[i]) * c_SQ_W'(w_absDy[i]);
            w_rad[i]   = c_SQ_W'(r_s1W[i]) * c_SQ_W'(r_s1W[i]);
            if (r_s1Shape[i])
                w_cover[i] = r_s1En[i] && (w_dist[i] <= w_rad[i]);
            else
                w_cover[i] = r_s1En[i] && (w_absDx[i] <= {1'b0, r_s1W[i]})
                                       && (w_absDy[i] <= {1'b0, r_s1H[i]});
        end
    end

    logic [NUM_OBJ-1:0] r_s2Cover;
    logic [c_RGB_W-1:0] r_s2Rgb [NUM_OBJ];
    logic [COLOR_W-1:0] r_s2Bg;
    logic               r_s2Valid;

    always_ff @(posedge Clk) begin
        r_s2Cover <= w_cover;
        r_s2Bg    <= r_s1Bg;
        for (int i = 0; i < NUM_OBJ; i++) r_s2Rgb[i] <= r_s1Rgb[i];
    end

    // ---------------- S3: priority encode, colour select, collision
    logic [IDX_W-1:0]   w_winIdx;
    logic [c_RGB_W-1:0] w_winRgb;
    logic [NUM_OBJ-1:0] w_contrib;
    logic [NUM_OBJ-1:0] r_collAcc;

    always_comb begin
        w_winIdx = '0;
        w_winRgb = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (r_s2Cover[i]) begin
                w_winIdx = IDX_W'(i);
                w_winRgb = r_s2Rgb[i];
            end
        end
        // More than one bit set <=> clearing the lowest set bit leaves something.
        w_contrib = '0;
        if (r_s2Valid && (|(r_s2Cover & (r_s2Cover - NUM_OBJ'(1)))))
            w_contrib = r_s2Cover;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1Valid       <= 1'b0;
            r_s2Valid       <= 1'b0;
            out_valid       <= 1'b0;
            Red             <= '0;
            Green           <= '0;
            Blue            <= '0;
            hit             <= 1'b0;
            hit_idx         <= '0;
            r_collAcc       <= '0;
            frame_collision <= '0;
        end else begin
            r_s1Valid <= pix_valid;
            r_s2Valid <= r_s1Valid;
            out_valid <= r_s2Valid;
            if (r_s2Valid) begin
                hit     <= |r_s2Cover;
                hit_idx <= w_winIdx;
                if (|r_s2Cover) begin
                    {Red, Green, Blue} <= w_winRgb;
                end else begin
                    Red   <= '0;
                    Green <= '0;
                    Blue  <= r_s2Bg;
                end
            end
            if (frame_start) begin
                frame_collision <= r_collAcc | w_contrib;
                r_collAcc       <= '0;
            end else begin
                r_collAcc <= r_collAcc | w_contrib;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_object_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_object_compositor
// Brief    : Randomised scoreboard bench for object_compositor against a
//            geometric reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_object_compositor;

    localparam int NUM_OBJ = 4;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;
    localparam int IDX_W   = 2;
    localparam int c_VAL_W = 1 + IDX_W + 3 * COLOR_W;

    logic                 Clk, Reset, cfg_wr, cfg_en, cfg_shape, frame_start, pix_valid;
    logic [IDX_W-1:0]     cfg_obj;
    logic [COORD_W-1:0]   cfg_x, cfg_y, cfg_w, cfg_h, DrawX, DrawY;
    logic [3*COLOR_W-1:0] cfg_rgb;
    logic                 out_valid, hit;
    logic [COLOR_W-1:0]   Red, Green, Blue;
    logic [IDX_W-1:0]     hit_idx;
    logic [NUM_OBJ-1:0]   frame_collision;

    object_compositor #(.NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .IDX_W(IDX_W)) dut (
        .Clk(Clk), .Reset(Reset), .cfg_wr(cfg_wr), .cfg_obj(cfg_obj), .cfg_en(cfg_en),
        .cfg_shape(cfg_shape), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_rgb(cfg_rgb), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .out_valid(out_valid), .Red(Red), .Green(Green),
        .Blue(Blue), .hit(hit), .hit_idx(hit_idx), .frame_collision(frame_collision)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [c_VAL_W-1:0] val; } exp_t;
    typedef struct { int cyc; logic [NUM_OBJ-1:0] cov; } col_t;
    typedef struct { bit en; bit shape; int x; int y; int w; int h; logic [23:0] rgb; } mobj_t;

    exp_t  sb[$];
    col_t  colQ[$];
    mobj_t mSh[NUM_OBJ];
    mobj_t mAct[NUM_OBJ];

    int nCmp = 0;
    int nFail = 0;
    bit collPending = 0;
    logic [NUM_OBJ-1:0] collExp;

    bit nPix, nCfg, nFs, nEn, nShape;
    int nX, nY, nObj, nCx, nCy, nCw, nCh;
    logic [23:0] nRgb;

    function automatic bit covers(mobj_t o, int px, int py);
        int dx = px - o.x;
        int dy = py - o.y;
        if (!o.en) return 1'b0;
        if (o.shape) return (dx * dx + dy * dy) <= (o.w * o.w);
        return ((dx < 0 ? -dx : dx) <= o.w) && ((dy < 0 ? -dy : dy) <= o.h);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        nCmp++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, want);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_OBJ; i++) begin
            mSh[i]  = '{0, 0, 0, 0, 0, 0, 24'h0};
            mAct[i] = '{0, 0, 0, 0, 0, 0, 24'h0};
        end
    endtask

    // One clock of stimulus taken from the n* variables, with model update.
    task automatic step();
        logic [NUM_OBJ-1:0] cv;
        logic [IDX_W-1:0]   idx;
        logic [23:0]        rgb;
        exp_t               e;
        @(negedge Clk);
        if (collPending) begin
            chk("frame_collision", 32'(frame_collision), 32'(collExp));
            collPending = 0;
        end
        pix_valid   = nPix;
        DrawX       = nX[COORD_W-1:0];
        DrawY       = nY[COORD_W-1:0];
        frame_start = nFs;
        cfg_wr      = nCfg;
        cfg_obj     = nObj[IDX_W-1:0];
        cfg_en      = nEn;
        cfg_shape   = nShape;
        cfg_x       = nCx[COORD_W-1:0];
        cfg_y       = nCy[COORD_W-1:0];
        cfg_w       = nCw[COORD_W-1:0];
        cfg_h       = nCh[COORD_W-1:0];
        cfg_rgb     = nRgb;
        if (nPix) begin
            cv = '0;
            idx = '0;
            rgb = {16'h0, 8'(127 - (nX >> 3))};
            for (int i = 0; i < NUM_OBJ; i++) cv[i] = covers(mAct[i], nX, nY);
            for (int i = NUM_OBJ - 1; i >= 0; i--) if (cv[i]) begin idx = IDX_W'(i); rgb = mAct[i].rgb; end
            e.cyc = cyc + 3;
            e.val = {|cv, idx, rgb};
            sb.push_back(e);
            if ($countones(cv) >= 2) colQ.push_back('{cyc, cv});
        end
        if (nFs) begin
            collExp = '0;
            while (colQ.size() > 0 && colQ[0].cyc <= cyc - 2) collExp |= colQ.pop_front().cov;
            collPending = 1;
            for (int i = 0; i < NUM_OBJ; i++) mAct[i] = mSh[i];
        end
        if (nCfg && nObj < NUM_OBJ) mSh[nObj] = '{nEn, nShape, nCx, nCy, nCw, nCh, nRgb};
        nPix = 0; nCfg = 0; nFs = 0;
    endtask

    task automatic setCfg(int o, bit en, bit sh, int x, int y, int w, int h, logic [23:0] rgb);
        nCfg = 1; nObj = o; nEn = en; nShape = sh; nCx = x; nCy = y; nCw = w; nCh = h; nRgb = rgb;
    endtask

    task automatic pix(int x, int y);
        nPix = 1; nX = x; nY = y; step();
    endtask

    task automatic fs();
        nFs = 1; step();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic midReset();
        @(posedge Clk);
        #1;
        Reset = 1; pix_valid = 0; cfg_wr = 0; frame_start = 0;
        while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
        colQ.delete();
        collPending = 0;
        clearModel();
        @(posedge Clk);
        #1;
        Reset = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel.
    exp_t mE;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (out_valid) begin
                nCmp++;
                if (sb.size() == 0) begin
                    nFail++;
                    $display("FAIL spurious_out_valid cycle=%0d got=%0h", cyc, {hit, hit_idx, Red, Green, Blue});
                end else begin
                    mE = sb.pop_front();
                    if (mE.cyc != cyc || {hit, hit_idx, Red, Green, Blue} !== mE.val) begin
                        nFail++;
                        $display("FAIL pixel cycle=%0d got={hit,idx,rgb}=%0h exp=%0h at cycle %0d",
                                 cyc, {hit, hit_idx, Red, Green, Blue}, mE.val, mE.cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                nCmp++;
                nFail++;
                $display("FAIL missing_out_valid cycle=%0d got=0 exp=1 val=%0h", cyc, sb[0].val);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        Reset = 1; pix_valid = 0; frame_start = 0; cfg_wr = 0; cfg_obj = '0; cfg_en = 0;
        cfg_shape = 0; cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_rgb = '0;
        DrawX = '0; DrawY = '0;
        nPix = 0; nCfg = 0; nFs = 0; nX = 0; nY = 0; nObj = 0; nEn = 0; nShape = 0;
        nCx = 0; nCy = 0; nCw = 0; nCh = 0; nRgb = '0; collExp = '0;
        clearModel();
        repeat (3) @(negedge Clk);
        Reset = 0;
        @(negedge Clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({Red, Green, Blue}), 32'd0);
        chk("rst_hit", 32'({hit, hit_idx}), 32'd0);
        chk("rst_frame_collision", 32'(frame_collision), 32'd0);

        // Background only, then a rectangle with edge probes.
        pix(80, 10);
        setCfg(0, 1, 0, 100, 100, 2, 47, 24'hFF5500); step();
        fs();
        pix(102, 147); pix(103, 100); pix(102, 148); pix(98, 53);
        // Circle near the origin: negative offsets must not wrap.
        setCfg(1, 1, 1, 5, 5, 4, 0, 24'h00FF00); step();
        fs();
        pix(1, 5); pix(0, 0); pix(8, 8); pix(5, 9); pix(5, 10);
        idle(4);

        // Overlapping rectangles: priority then collision flags.
        setCfg(0, 1, 0, 200, 200, 3, 3, 24'h0000FF); step();
        setCfg(1, 1, 0, 202, 200, 3, 3, 24'hFFFFFF); step();
        fs();
        pix(200, 200); pix(201, 200); pix(204, 200); pix(190, 200);
        idle(4);
        fs();
        setCfg(1, 1, 0, 500, 500, 3, 3, 24'hFFFFFF); step();
        idle(1);
        fs();
        pix(200, 200); idle(4);
        fs();
        idle(2);

        // Double buffer: shadow write mid-frame, then a write colliding with frame_start.
        nPix = 1; nX = 300; nY = 200; setCfg(0, 1, 0, 300, 200, 3, 3, 24'h0000FF); step();
        for (int i = 0; i < 5; i++) pix(300, 200);
        nPix = 1; nX = 300; nY = 200; nFs = 1; setCfg(0, 1, 0, 400, 200, 3, 3, 24'h0000FF); step();
        pix(300, 200); pix(400, 200); pix(300, 200);
        fs();
        pix(300, 200); pix(400, 200);
        idle(4);

        // Randomised traffic.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    setCfg($urandom_range(0, NUM_OBJ - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(900, 1023), $urandom_range(0, 1023),
                           $urandom_range(0, 1023), $urandom_range(0, 1023), 24'($urandom));
                else
                    setCfg($urandom_range(0, NUM_OBJ - 1), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 40), $urandom_range(0, 40),
                           $urandom_range(0, 12), $urandom_range(0, 12), 24'($urandom));
            end
            if ($urandom_range(0, 24) == 0) nFs = 1;
            if ($urandom_range(0, 4) != 0) begin
                nPix = 1;
                if ($urandom_range(0, 4) == 0) begin
                    nX = $urandom_range(0, 1023); nY = $urandom_range(0, 1023);
                end else begin
                    nX = $urandom_range(0, 55); nY = $urandom_range(0, 55);
                end
            end
            step();
        end
        idle(4);
        fs();
        idle(2);

        // Stream with a 2-cycle gap, then reset with pixels in flight.
        setCfg(0, 1, 0, 20, 20, 5, 5, 24'h123456); step();
        fs();
        for (int i = 0; i < 5; i++) pix(16 + i, 20);
        idle(2);
        for (int i = 0; i < 3; i++) pix(30 + i, 20);
        midReset();
        @(negedge Clk);
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_frame_collision", 32'(frame_collision), 32'd0);
        idle(5);
        pix(20, 20); pix(640, 0);
        idle(5);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
